// File: rtl/uart_pkg.sv
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared types and helpers for the UART receive/transmit paths.
//            Parity-mode encodings, receiver FSM state enum and the
//            phase-accumulator width function used by uart_tick_gen.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Largest value the accumulator ever holds is (clk_freq - 1) + inc.
  function automatic int acc_width(input longint clk_freq, input longint inc);
    return $clog2(clk_freq + inc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
//  Module  : uart_tick_gen
//  Purpose : Fractional phase-accumulator tick generator. Adds INC every
//            clock; when the sum reaches CLK_FREQ it wraps and emits a
//            one-cycle tick, so the mean tick rate is exactly
//            INC / CLK_FREQ ticks per clock.
//  Ports   : clk_i   in  system clock
//            rst_ni  in  asynchronous active-low reset
//            clr_i   in  synchronous clear (realigns the tick phase)
//            tick_o  out one-cycle tick pulse (registered)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tick_gen #(
  parameter int CLK_FREQ = 150_000_000,
  parameter int INC      = 48_000_000,
  parameter int ACC_W    = 28
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [ACC_W-1:0] FREQ_C = ACC_W'(CLK_FREQ);
  localparam logic [ACC_W-1:0] INC_C  = ACC_W'(INC);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             tick_q, tick_d;

  always_comb begin
    sum    = acc_q + INC_C;
    acc_d  = sum;
    tick_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (sum >= FREQ_C) begin
      acc_d  = sum - FREQ_C;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
//  Module  : uart_rx_frame
//  Purpose : Parametrised UART receiver. 2-flop input synchroniser,
//            fractional baud tick, 3-sample majority vote per bit,
//            optional parity, 1 or 2 stop bits, framing/parity error flags
//            and a ready/valid output with overrun pulse.
//  Ports   : CLK in, RST_N in (async, active-low), RXD in (async serial),
//            DOUT out [DATA_BITS], DVALID out, DREADY in, PERR out,
//            FERR out, OVERRUN out (1-cycle pulse), BUSY out,
//            BREAK out (only with UART_RX_BREAK_DET_EN)
//  Config  : define UART_RX_BREAK_DET_EN to enable break detection.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int UART_CLK_FREQ = 150_000_000,
  parameter int BAUD_RATE     = 3_000_000,
  parameter int OVERSAMPLING  = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 DVALID,
  input  logic                 DREADY,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 OVERRUN,
  output logic                 BUSY
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 BREAK
`endif
);

  localparam int ACC_W = acc_width(UART_CLK_FREQ, BAUD_RATE * OVERSAMPLING);
  localparam int TCW   = $clog2(OVERSAMPLING);
  localparam int BCW   = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q;
  logic [TCW-1:0]       tick_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q, dout_q;
  logic                 perr_q, ferr_q;
  logic                 dvalid_q, perr_out_q, ferr_out_q, ovr_q, busy_q;

  logic tick, start_det, vote, mid_pt, bit_end, frame_done, brk_frame;

  assign start_det  = (state_q == IDLE) && prev_q && !sync2_q;
  // Third sample is the live synchronised value at the last vote tick.
  assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) |
                      (samp_q[1] & sync2_q);
  assign mid_pt     = tick && (tick_cnt_q == TCW'(OVERSAMPLING/2 + 1));
  assign bit_end    = tick && (tick_cnt_q == TCW'(OVERSAMPLING - 1));
  assign frame_done = (state_q == STOP) && mid_pt &&
                      (bit_cnt_q == BCW'(STOP_BITS - 1));

  uart_tick_gen #(
    .CLK_FREQ (UART_CLK_FREQ),
    .INC      (BAUD_RATE * OVERSAMPLING),
    .ACC_W    (ACC_W)
  ) u_tick (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (start_det),
    .tick_o (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ovr_q   <= 1'b0;

      if (dvalid_q && DREADY) dvalid_q <= 1'b0;

      if (tick) begin
        if (tick_cnt_q == TCW'(OVERSAMPLING/2 - 1)) samp_q[0] <= sync2_q;
        if (tick_cnt_q == TCW'(OVERSAMPLING/2))     samp_q[1] <= sync2_q;
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q    <= START;
            busy_q     <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end else if (bit_end) begin
            // Tail of the last stop bit: FSM re-armed at mid-bit, BUSY
            // holds until the bit period is over.
            busy_q <= 1'b0;
          end
        end
        START: begin
          if (mid_pt && vote) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (mid_pt) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (mid_pt) perr_q <= (^shift_q) ^ vote ^ (PARITY_MODE == PAR_ODD);
          if (bit_end) state_q <= STOP;
        end
        STOP: begin
          if (frame_done) begin
            state_q <= IDLE;
            if (!brk_frame) begin
              if (!dvalid_q || DREADY) begin
                dout_q     <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_q | ~vote;
                dvalid_q   <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end else if (mid_pt) begin
            ferr_q <= ferr_q | ~vote;
          end
          if (bit_end) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic           all_zero_q, break_q;
  logic [TCW-1:0] brk_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      all_zero_q <= 1'b0;
      break_q    <= 1'b0;
      brk_cnt_q  <= '0;
    end else begin
      // Tracks whether every data/parity/stop vote so far was 0.
      if (start_det) begin
        all_zero_q <= 1'b1;
      end else if (mid_pt && vote && state_q != IDLE && state_q != START) begin
        all_zero_q <= 1'b0;
      end

      if (frame_done && brk_frame) begin
        break_q   <= 1'b1;
        brk_cnt_q <= '0;
      end else if (break_q) begin
        // Clear only after the line has been high for a full bit period.
        if (!sync2_q) begin
          brk_cnt_q <= '0;
        end else if (tick) begin
          if (brk_cnt_q == TCW'(OVERSAMPLING - 1)) break_q <= 1'b0;
          else brk_cnt_q <= brk_cnt_q + 1'b1;
        end
      end
    end
  end

  assign brk_frame = all_zero_q & ~vote;
  assign BREAK     = break_q;
`else
  assign brk_frame = 1'b0;
`endif

  assign DOUT    = dout_q;
  assign DVALID  = dvalid_q;
  assign PERR    = perr_out_q;
  assign FERR    = ferr_out_q;
  assign OVERRUN = ovr_q;
  assign BUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
//  Module  : tb_uart_rx_frame
//  Purpose : Directed self-checking bench for uart_rx_frame. Three
//            instances: 8N1 default, 8E1 (even parity) and 8N2.
//            At 150 MHz / 3 Mbaud one bit lasts 50 clocks.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_frame;

  localparam int BIT_CLKS = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rxd0, rxd1, rxd2;
  logic       dready0, dready1, dready2;
  logic [7:0] dout0, dout1, dout2;
  logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2;
  logic       ov0, ov1, ov2, busy0, busy1, busy2;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk0, brk1, brk2;
`endif

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;

  uart_rx_frame u_dut0 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd0), .DOUT(dout0), .DVALID(dv0),
    .DREADY(dready0), .PERR(pe0), .FERR(fe0), .OVERRUN(ov0), .BUSY(busy0)
`ifdef UART_RX_BREAK_DET_EN
    , .BREAK(brk0)
`endif
  );

  uart_rx_frame #(.PARITY_MODE(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd1), .DOUT(dout1), .DVALID(dv1),
    .DREADY(dready1), .PERR(pe1), .FERR(fe1), .OVERRUN(ov1), .BUSY(busy1)
`ifdef UART_RX_BREAK_DET_EN
    , .BREAK(brk1)
`endif
  );

  uart_rx_frame #(.STOP_BITS(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd2), .DOUT(dout2), .DVALID(dv2),
    .DREADY(dready2), .PERR(pe2), .FERR(fe2), .OVERRUN(ov2), .BUSY(busy2)
`ifdef UART_RX_BREAK_DET_EN
    , .BREAK(brk2)
`endif
  );

  always @(negedge clk) if (ov0 === 1'b1) ov_cnt++;

  task automatic set_rxd(input int which, input logic v);
    case (which)
      0:       rxd0 = v;
      1:       rxd1 = v;
      default: rxd2 = v;
    endcase
  endtask

  task automatic hold_bit(input int which, input logic v);
    set_rxd(which, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data,
                            input bit has_par, input logic par,
                            input int nstop, input logic s1, input logic s2);
    hold_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(which, data[i]);
    if (has_par) hold_bit(which, par);
    hold_bit(which, s1);
    if (nstop == 2) hold_bit(which, s2);
    set_rxd(which, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({dout0, dv0, pe0, fe0, ov0, busy0} !== 13'd0)
      $display("FAIL reset_dut0: got %h want 0", {dout0, dv0, pe0, fe0, ov0, busy0});
    total++;
    if ({dout1, dv1, pe1, fe1, ov1, busy1} !== 13'd0)
      $display("FAIL reset_dut1: got %h want 0", {dout1, dv1, pe1, fe1, ov1, busy1});
    total++;
    if ({dout2, dv2, pe2, fe2, ov2, busy2} !== 13'd0)
      $display("FAIL reset_dut2: got %h want 0", {dout2, dv2, pe2, fe2, ov2, busy2});
`ifdef UART_RX_BREAK_DET_EN
    total++;
    if ({brk0, brk1, brk2} !== 3'b000)
      $display("FAIL reset_break: got %b want 000", {brk0, brk1, brk2});
`endif
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_basic;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (dv0 !== 1'b1) begin bad++; $display("FAIL basic_dvalid: got %b want 1", dv0); end
    total++; if (dout0 !== 8'hA5) begin bad++; $display("FAIL basic_dout: got %h want a5", dout0); end
    total++; if ({pe0, fe0} !== 2'b00) begin bad++; $display("FAIL basic_errs: got %b want 00", {pe0, fe0}); end
    dready0 = 1'b1;
    @(negedge clk);
    dready0 = 1'b0;
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL basic_dvalid_drop: got %b want 0", dv0); end
    repeat (10) @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy0); end
  endtask

  task automatic test_parity;
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    @(negedge clk);
    total++; if ({dv1, dout1} !== 9'h13C) begin bad++; $display("FAIL par_ok_dout: got %h want 13c", {dv1, dout1}); end
    total++; if ({pe1, fe1} !== 2'b00) begin bad++; $display("FAIL par_ok_errs: got %b want 00", {pe1, fe1}); end
    dready1 = 1'b1; @(negedge clk); dready1 = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    @(negedge clk);
    total++; if ({dv1, dout1} !== 9'h13C) begin bad++; $display("FAIL par_bad_dout: got %h want 13c", {dv1, dout1}); end
    total++; if ({pe1, fe1} !== 2'b10) begin bad++; $display("FAIL par_bad_errs: got %b want 10", {pe1, fe1}); end
    dready1 = 1'b1; @(negedge clk); dready1 = 1'b0;
  endtask

  task automatic test_stop2;
    send_frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    total++; if ({dv2, dout2} !== 9'h155) begin bad++; $display("FAIL stop2_dout: got %h want 155", {dv2, dout2}); end
    total++; if ({pe2, fe2} !== 2'b01) begin bad++; $display("FAIL stop2_ferr: got %b want 01", {pe2, fe2}); end
    dready2 = 1'b1; @(negedge clk); dready2 = 1'b0;
    send_frame(2, 8'h0F, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    @(negedge clk);
    total++; if ({dv2, dout2} !== 9'h10F) begin bad++; $display("FAIL stop2_next_dout: got %h want 10f", {dv2, dout2}); end
    total++; if ({pe2, fe2} !== 2'b00) begin bad++; $display("FAIL stop2_next_errs: got %b want 00", {pe2, fe2}); end
    dready2 = 1'b1; @(negedge clk); dready2 = 1'b0;
  endtask

  task automatic test_glitch;
    int seen_dv;
    seen_dv = 0;
    rxd0 = 1'b0;
    repeat (3) @(negedge clk);
    rxd0 = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise: got %b want 1", busy0); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dv0 === 1'b1) seen_dv++;
    end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall: got %b want 0", busy0); end
    total++; if (seen_dv !== 0) begin bad++; $display("FAIL glitch_no_dvalid: got %0d cycles want 0", seen_dv); end
  endtask

  task automatic test_back_to_back;
    dready0 = 1'b0;
    ov_cnt  = 0;
    send_frame(0, 8'h12, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    total++; if ({dv0, dout0} !== 9'h112) begin bad++; $display("FAIL ovr_keep_old: got %h want 112", {dv0, dout0}); end
    total++; if (ov_cnt !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt); end
    dready0 = 1'b1; @(negedge clk); dready0 = 1'b0;
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", dv0); end
    send_frame(0, 8'h56, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    @(negedge clk);
    total++; if ({dv0, dout0} !== 9'h156) begin bad++; $display("FAIL ovr_next_dout: got %h want 156", {dv0, dout0}); end
  endtask

  task automatic test_reset_mid;
    // 0x56 is still held in DOUT with DVALID high.
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    hold_bit(0, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy0); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dout0, dv0, pe0, fe0, ov0, busy0} !== 13'd0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0", {dout0, dv0, pe0, fe0, ov0, busy0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL rstmid_no_partial: got %b want 0", dv0); end
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    @(negedge clk);
    total++; if ({dv0, dout0} !== 9'h181) begin bad++; $display("FAIL rstmid_after: got %h want 181", {dv0, dout0}); end
    total++; if ({pe0, fe0} !== 2'b00) begin bad++; $display("FAIL rstmid_after_errs: got %b want 00", {pe0, fe0}); end
  endtask

  // test_reset counts its own failures through a wrapper so the counter
  // stays the one the summary prints.
  int bad_before;

  initial begin
    rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
    dready0 = 1'b0; dready1 = 1'b0; dready2 = 1'b0;
    rst_n = 1'b0;
    bad_before = 0;
    test_reset_counted();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic test_reset_counted;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({dout0, dv0, pe0, fe0, ov0, busy0} !== 13'd0) begin
      bad++; $display("FAIL reset_dut0: got %h want 0", {dout0, dv0, pe0, fe0, ov0, busy0});
    end
    total++;
    if ({dout1, dv1, pe1, fe1, ov1, busy1} !== 13'd0) begin
      bad++; $display("FAIL reset_dut1: got %h want 0", {dout1, dv1, pe1, fe1, ov1, busy1});
    end
    total++;
    if ({dout2, dv2, pe2, fe2, ov2, busy2} !== 13'd0) begin
      bad++; $display("FAIL reset_dut2: got %h want 0", {dout2, dv2, pe2, fe2, ov2, busy2});
    end
`ifdef UART_RX_BREAK_DET_EN
    total++;
    if ({brk0, brk1, brk2} !== 3'b000) begin
      bad++; $display("FAIL reset_break: got %b want 000", {brk0, brk1, brk2});
    end
`endif
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
